// File: rtl/bcd_pkg.sv
// bcd_pkg: shared constants, state encoding and elaboration helpers for bin2bcd_seq.
// Revision: 1.0
`default_nettype none

package bcd_pkg;

  localparam int DIGIT_W    = 4;
  localparam int ADJ_THRESH = 5;
  localparam int ADJ_ADD    = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CONV = 1'b1
  } state_t;

  function automatic int unsigned pow10(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/bcd_digit_adj.sv
// bcd_digit_adj: combinational add-3-if-at-least-5 cell for one BCD digit.
// Revision: 1.0
`default_nettype none

module bcd_digit_adj
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit_in,
  output logic [DIGIT_W-1:0] digit_out
);

  assign digit_out = (digit_in >= DIGIT_W'(ADJ_THRESH)) ? digit_in + DIGIT_W'(ADJ_ADD)
                                                        : digit_in;

endmodule

`default_nettype wire

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: one-bit-per-clock double-dabble binary to BCD converter with start/busy/done.
// Revision: 1.0
`default_nettype none

module bin2bcd_seq
  import bcd_pkg::*;
#(
  parameter int N_BITS   = 14,
  parameter int N_DIGITS = 4
) (
  input  logic                        clk,
  input  logic                        clr_n,
  input  logic                        start,
  input  logic [N_BITS-1:0]           bin_in,
  output logic                        busy,
  output logic                        done,
  output logic [DIGIT_W*N_DIGITS-1:0] bcd_out,
  output logic                        overflow
);

  localparam int          BCD_W          = DIGIT_W * N_DIGITS;
  localparam int          CNT_W          = (N_BITS > 1) ? $clog2(N_BITS) : 1;
  localparam int unsigned OVF_LIMIT_FULL = pow10(N_DIGITS) - 1;
  localparam logic [N_BITS:0] OVF_LIMIT  = OVF_LIMIT_FULL[N_BITS:0];

  state_t             state;
  logic [CNT_W-1:0]   bit_cnt;
  logic [N_BITS-1:0]  shift_reg;
  logic [BCD_W-1:0]   scratch;
  logic [BCD_W-1:0]   scratch_adj;
  logic [BCD_W-1:0]   scratch_next;
  logic               ovf_lat;
  logic               ovf_cmp;

  for (genvar g = 0; g < N_DIGITS; g++) begin : g_adj
    bcd_digit_adj u_adj (
      .digit_in  (scratch[g*DIGIT_W +: DIGIT_W]),
      .digit_out (scratch_adj[g*DIGIT_W +: DIGIT_W])
    );
  end

  // Carry out of the top digit falls off here, giving bin_in mod 10^N_DIGITS.
  assign scratch_next = BCD_W'({scratch_adj, shift_reg[N_BITS-1]});
  assign ovf_cmp      = {1'b0, bin_in} > OVF_LIMIT;

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state     <= ST_IDLE;
      bit_cnt   <= '0;
      shift_reg <= '0;
      scratch   <= '0;
      ovf_lat   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      bcd_out   <= '0;
      overflow  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            shift_reg <= bin_in;
            scratch   <= '0;
            bit_cnt   <= CNT_W'(N_BITS - 1);
            ovf_lat   <= ovf_cmp;
            busy      <= 1'b1;
            state     <= ST_CONV;
          end
        end
        ST_CONV: begin
          scratch   <= scratch_next;
          shift_reg <= {shift_reg[N_BITS-2:0], 1'b0};
          if (bit_cnt == '0) begin
            bcd_out  <= scratch_next;
            overflow <= ovf_lat;
            done     <= 1'b1;
            busy     <= 1'b0;
            state    <= ST_IDLE;
          end else begin
            bit_cnt <= bit_cnt - 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_bin2bcd_seq.sv
// tb_bin2bcd_seq: directed vector table plus multi-cycle corner sequences for bin2bcd_seq.
// Revision: 1.0
`default_nettype none

module tb_bin2bcd_seq;

  logic        clk;
  logic        clr_n;
  logic        start;
  logic [13:0] bin_in;
  logic        busy;
  logic        done;
  logic [15:0] bcd_out;
  logic        overflow;

  int checks   = 0;
  int failures = 0;
  logic [15:0] prev_bcd;

  bin2bcd_seq #(.N_BITS(14), .N_DIGITS(4)) dut (
    .clk      (clk),
    .clr_n    (clr_n),
    .start    (start),
    .bin_in   (bin_in),
    .busy     (busy),
    .done     (done),
    .bcd_out  (bcd_out),
    .overflow (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [13:0] bin;
    logic [15:0] bcd;
    logic        ovf;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic run_conv(input logic [13:0] v, input logic [15:0] eb, input logic eo);
    int lat;
    int bcnt;
    bit hold_ok;
    lat     = 0;
    bcnt    = 0;
    hold_ok = 1'b1;
    bin_in  = v;
    start   = 1'b1;
    tick();
    start  = 1'b0;
    bin_in = 14'($urandom);
    if (busy) bcnt++;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (done) begin
        lat = n;
        break;
      end
      if (busy) bcnt++;
      if (bcd_out !== prev_bcd) hold_ok = 1'b0;
    end
    check("latency", lat, 14);
    check("busy_cycles", bcnt, 14);
    check("busy_at_done", {31'd0, busy}, 32'd0);
    check("bcd_out", {16'd0, bcd_out}, {16'd0, eb});
    check("overflow", {31'd0, overflow}, {31'd0, eo});
    check("bcd_hold", {31'd0, hold_ok}, 32'd1);
    tick();
    check("done_one_cycle", {31'd0, done}, 32'd0);
    prev_bcd = eb;
  endtask

  initial begin
    int done_cnt;
    int done_at;
    int last_done;
    bit busy_ok;
    logic [15:0] got;

    vecs[0] = '{14'd0,     16'h0000, 1'b0};
    vecs[1] = '{14'd1234,  16'h1234, 1'b0};
    vecs[2] = '{14'd9999,  16'h9999, 1'b0};
    vecs[3] = '{14'd16383, 16'h6383, 1'b1};
    vecs[4] = '{14'd10000, 16'h0000, 1'b1};
    vecs[5] = '{14'd42,    16'h0042, 1'b0};
    vecs[6] = '{14'd1,     16'h0001, 1'b0};
    vecs[7] = '{14'd8191,  16'h8191, 1'b0};
    vecs[8] = '{14'd10,    16'h0010, 1'b0};
    vecs[9] = '{14'd5,     16'h0005, 1'b0};

    clr_n    = 1'b0;
    start    = 1'b0;
    bin_in   = '0;
    prev_bcd = '0;
    #12;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bcd", {16'd0, bcd_out}, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);
    tick();
    clr_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].bin, vecs[i].bcd, vecs[i].ovf);
    end

    // start and bin_in disturbed mid-conversion
    done_cnt = 0;
    done_at  = 0;
    got      = '0;
    bin_in   = 14'd505;
    start    = 1'b1;
    tick();
    for (int n = 1; n <= 30; n++) begin
      if (n == 3 || n == 9) begin
        start  = 1'b1;
        bin_in = 14'd777;
      end else begin
        start = 1'b0;
      end
      tick();
      if (done) begin
        done_cnt++;
        done_at = n;
        got     = bcd_out;
      end
    end
    start = 1'b0;
    check("ignore_start_dones", done_cnt, 1);
    check("ignore_start_latency", done_at, 14);
    check("ignore_start_bcd", {16'd0, got}, 32'h0505);
    prev_bcd = 16'h0505;

    // asynchronous clear mid-conversion
    bin_in = 14'd4321;
    start  = 1'b1;
    tick();
    start = 1'b0;
    repeat (6) tick();
    #2;
    clr_n = 1'b0;
    #1;
    check("clr_busy", {31'd0, busy}, 32'd0);
    check("clr_done", {31'd0, done}, 32'd0);
    check("clr_bcd", {16'd0, bcd_out}, 32'd0);
    check("clr_ovf", {31'd0, overflow}, 32'd0);
    tick();
    tick();
    clr_n    = 1'b1;
    done_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (done) done_cnt++;
    end
    check("clr_no_done", done_cnt, 0);
    prev_bcd = '0;
    run_conv(14'd88, 16'h0088, 1'b0);

    // start held high: back-to-back conversions
    done_cnt  = 0;
    last_done = 0;
    busy_ok   = 1'b1;
    bin_in    = 14'd59;
    start     = 1'b1;
    tick();
    for (int n = 1; n <= 60; n++) begin
      tick();
      if (busy === done) busy_ok = 1'b0;
      if (done) begin
        done_cnt++;
        check("b2b_bcd", {16'd0, bcd_out}, 32'h0059);
        if (last_done != 0) check("b2b_interval", n - last_done, 15);
        last_done = n;
      end
    end
    start = 1'b0;
    check("b2b_dones", done_cnt, 4);
    check("b2b_busy_pattern", {31'd0, busy_ok}, 32'd1);
    for (int n = 0; n < 20 && busy; n++) tick();
    check("b2b_idle", {31'd0, busy}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
